wb_retire_checker: RTL and testbench
====================================

Name: wb_retire_checker

Overview:
- Synthesizable self-check block for the LEGv8 CPU tops (single-cycle and pipeline); replaces ad-hoc testbench wait/compare loops.
- Monitors the retire stream (write-back instruction, destination register, write data) against a preloaded table of expected register writes.
- Detects program end on a configurable halt instruction, and reports pass/fail, failure cause, failing index and cycle count.
- Instantiated beside PipelineCPU/SingleCycleCPU in bench tops; also usable on FPGA with status driven to LEDs.

Parameters:
- WORD, 64, data width of write-back value
- INST_SIZE, 32, instruction width
- REG_W, 5, register index width
- DEPTH, 16, expected-table entries (power of 2)
- HALT_INST, 32'h14000000, retire encoding that ends the run (B #0)
- TIMEOUT, 1000000, cycles in RUN before declaring timeout
- CNT_W, 32, width of cycle and match counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- exp_we  in  1  table write strobe; honoured in IDLE, PASS and FAIL only
- exp_addr  in  log2(DEPTH)  table write index
- exp_reg  in  REG_W  expected destination register
- exp_data  in  WORD  expected write-back value
- num_exp  in  log2(DEPTH)+1  number of valid table entries (0..DEPTH); sampled on start
- start  in  1  begin or restart a check run
- wb_valid  in  1  an instruction retires this cycle
- wb_inst  in  INST_SIZE  retiring instruction
- wb_wen  in  1  retiring instruction writes the register file
- wb_reg  in  REG_W  destination register
- wb_data  in  WORD  write-back value
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  0 none, 1 data mismatch, 2 incomplete at halt, 3 timeout
- err_idx  out  log2(DEPTH)+1  table pointer at failure
- err_data  out  WORD  offending wb_data (0 for codes 2 and 3)
- match_cnt  out  CNT_W  entries matched so far
- cycle_cnt  out  CNT_W  cycles spent in RUN

Behaviour:
- States: IDLE, RUN, PASS, FAIL. All transitions occur on rising clk.
- Reset: state=IDLE; busy=done=pass=0; fail_code=0; err_idx=0; err_data=0; match_cnt=0; cycle_cnt=0; ptr=0. Table contents are not reset.
- Table write: exp_we writes {exp_reg, exp_data} at exp_addr one cycle later. exp_we is ignored in RUN.
- start in IDLE, PASS or FAIL:
  - Next state RUN; latch num_exp.
  - Clear ptr, match_cnt, cycle_cnt, fail_code, err_idx, err_data.
  - start in RUN is ignored.
- RUN, each cycle:
  - cycle_cnt increments by 1.
  - If cycle_cnt==TIMEOUT-1 and no other event this cycle: FAIL, fail_code=3, err_idx=ptr.
- RUN, retire with wb_valid=1 and wb_inst==HALT_INST (write compare is skipped for this retire):
  - ptr==num_exp: go to PASS.
  - Otherwise: FAIL, fail_code=2, err_idx=ptr.
- RUN, retire with wb_valid=1, wb_inst!=HALT_INST, wb_wen=1, wb_reg!=31, ptr<num_exp, and wb_reg==table[ptr].reg:
  - wb_data==table[ptr].data: ptr++ and match_cnt++.
  - Otherwise: FAIL, fail_code=1, err_idx=ptr, err_data=wb_data.
- RUN, ignored retires (no effect on ptr or status):
  - writes to other registers;
  - writes to X31/XZR;
  - writes once ptr==num_exp.
- Priority within one cycle: halt or compare result over timeout.
- Latency: status outputs reflect the retire that caused them on the cycle after that retire's edge.
- PASS and FAIL hold all outputs (cycle_cnt frozen) until start or rst.
- num_exp==0: the first halt passes.
- rst asserted mid-RUN: back to IDLE next edge with reset values; the table is preserved, so a re-run needs no reload.

Test Plan:
- Reset, load 3 entries {X9=1, X9=2, X9=0x27}, num_exp=3, start; retire those writes then 0x14000000 -> pass=1, match_cnt=3, fail_code=0.
- Same table; second retire X9=3 -> fail_code=1, err_idx=1, err_data=3, done=1 the next cycle.
- Same table; halt after two matches -> fail_code=2, err_idx=2.
- TIMEOUT=50 override, start, no retires -> fail_code=3 at cycle_cnt=49, busy=0 after.
- Interleave writes to X10 and XZR with value 0x99 between expected writes -> still pass, match_cnt=3; exp_we during RUN leaves the table unchanged (verify on a re-run).
- rst mid-RUN after one match -> IDLE with counters 0; start again with the same table -> pass.

Source files
------------

// File: rtl/wb_retire_checker.sv
// Retire-stream self-check: compares write-back writes against a preloaded table of
// expected {register, value} pairs and reports pass/fail when the halt instruction retires.
module wb_retire_checker #(
  parameter int                 WORD      = 64,
  parameter int                 INST_SIZE = 32,
  parameter int                 REG_W     = 5,
  parameter int                 DEPTH     = 16,
  parameter logic [INST_SIZE-1:0] HALT_INST = 32'h14000000,
  parameter int                 TIMEOUT   = 1000000,
  parameter int                 CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exp_we,
  input  logic [$clog2(DEPTH)-1:0]  exp_addr,
  input  logic [REG_W-1:0]          exp_reg,
  input  logic [WORD-1:0]           exp_data,
  input  logic [$clog2(DEPTH):0]    num_exp,
  input  logic                      start,
  input  logic                      wb_valid,
  input  logic [INST_SIZE-1:0]      wb_inst,
  input  logic                      wb_wen,
  input  logic [REG_W-1:0]          wb_reg,
  input  logic [WORD-1:0]           wb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                fail_code,
  output logic [$clog2(DEPTH):0]    err_idx,
  output logic [WORD-1:0]           err_data,
  output logic [CNT_W-1:0]          match_cnt,
  output logic [CNT_W-1:0]          cycle_cnt
);

  // state | meaning
  // IDLE  | waiting for start; table writable
  // RUN   | checking retires, counting cycles
  // PASS  | halt seen with every entry matched; outputs held
  // FAIL  | mismatch, early halt or timeout; outputs held

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0] XZR     = REG_W'(31);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_EARLY   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [REG_W-1:0] tbl_reg  [DEPTH];
  logic [WORD-1:0]  tbl_data [DEPTH];

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    num_lat;

  logic             in_run;
  logic             halt_ev;
  logic             cmp_ev;
  logic             match_ev;
  logic             mism_ev;
  logic             timeout_ev;
  logic             ptr_live;
  logic [REG_W-1:0] cur_reg;
  logic [WORD-1:0]  cur_data;

  // Table is frozen while a run is in flight so the reference cannot shift under it.
  always_ff @(posedge clk) begin
    if (exp_we && (state != S_RUN)) begin
      tbl_reg[exp_addr]  <= exp_reg;
      tbl_data[exp_addr] <= exp_data;
    end
  end

  assign in_run   = (state == S_RUN);
  assign ptr_live = (ptr < num_lat);
  assign cur_reg  = tbl_reg[ptr[AW-1:0]];
  assign cur_data = tbl_data[ptr[AW-1:0]];

  assign halt_ev  = in_run && wb_valid && (wb_inst == HALT_INST);
  assign cmp_ev   = in_run && wb_valid && (wb_inst != HALT_INST) && wb_wen &&
                    (wb_reg != XZR) && ptr_live && (wb_reg == cur_reg);
  assign match_ev = cmp_ev && (wb_data == cur_data);
  assign mism_ev  = cmp_ev && (wb_data != cur_data);
  // >= rather than == so a match landing on the last cycle cannot skip the limit.
  assign timeout_ev = in_run && (cycle_cnt >= TO_LAST) && !halt_ev && !cmp_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_ev) begin
          state_nxt = (ptr == num_lat) ? S_PASS : S_FAIL;
        end else if (mism_ev) begin
          state_nxt = S_FAIL;
        end else if (timeout_ev) begin
          state_nxt = S_FAIL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      S_RUN:  busy = 1'b1;
      S_PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      S_FAIL: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      num_lat   <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      fail_code <= FC_NONE;
      err_idx   <= '0;
      err_data  <= '0;
    end else if (!in_run) begin
      if (start) begin
        ptr       <= '0;
        num_lat   <= num_exp;
        match_cnt <= '0;
        cycle_cnt <= '0;
        fail_code <= FC_NONE;
        err_idx   <= '0;
        err_data  <= '0;
      end
    end else begin
      if (halt_ev) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (ptr != num_lat) begin
          fail_code <= FC_EARLY;
          err_idx   <= ptr;
        end
      end else if (match_ev) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        ptr       <= ptr + PW'(1);
        match_cnt <= match_cnt + CNT_W'(1);
      end else if (mism_ev) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        fail_code <= FC_DATA;
        err_idx   <= ptr;
        err_data  <= wb_data;
      end else if (timeout_ev) begin
        // Count freezes at TIMEOUT-1 so it reads as the last cycle checked.
        fail_code <= FC_TIMEOUT;
        err_idx   <= ptr;
      end else begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_checker.sv
// Scoreboard bench for wb_retire_checker: expected run outcomes are queued at start
// and compared when the checker reports done.
module tb_wb_retire_checker;

  localparam logic [31:0] HALT = 32'h14000000;
  localparam logic [31:0] ADDI = 32'h91000529;

  logic        clk = 1'b0;
  logic        rst;
  logic        exp_we;
  logic [3:0]  exp_addr;
  logic [4:0]  exp_reg;
  logic [63:0] exp_data;
  logic [4:0]  num_exp;
  logic        start;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic        wb_wen;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [4:0]  err_idx;
  logic [63:0] err_data;
  logic [31:0] match_cnt, cycle_cnt;

  wb_retire_checker #(
    .WORD(64), .INST_SIZE(32), .REG_W(5), .DEPTH(16),
    .HALT_INST(HALT), .TIMEOUT(50), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_reg(exp_reg), .exp_data(exp_data),
    .num_exp(num_exp), .start(start),
    .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_wen(wb_wen), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .err_idx(err_idx),
    .err_data(err_data), .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic [1:0]  code;
    logic [4:0]  idx;
    logic [63:0] data;
    logic [31:0] mcnt;
    logic [31:0] ccnt;
  } exp_t;

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rg;
    logic [63:0] d;
  } ret_t;

  exp_t exp_q[$];
  ret_t prog[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic p, input logic [1:0] c, input logic [4:0] i,
                                  input logic [63:0] d, input logic [31:0] m, input logic [31:0] cc);
    exp_t e;
    e.pass = p; e.code = c; e.idx = i; e.data = d; e.mcnt = m; e.ccnt = cc;
    return e;
  endfunction

  function automatic ret_t wr(input logic [4:0] r, input logic [63:0] d);
    ret_t x;
    x.v = 1'b1; x.inst = ADDI; x.wen = 1'b1; x.rg = r; x.d = d;
    return x;
  endfunction

  function automatic ret_t halt_r();
    ret_t x;
    x.v = 1'b1; x.inst = HALT; x.wen = 1'b0; x.rg = 5'd0; x.d = 64'd0;
    return x;
  endfunction

  function automatic ret_t bubble();
    ret_t x;
    x.v = 1'b0; x.inst = ADDI; x.wen = 1'b1; x.rg = 5'd9; x.d = 64'h99;
    return x;
  endfunction

  task automatic load_std_table();
    logic [63:0] vals [3];
    vals[0] = 64'd1; vals[1] = 64'd2; vals[2] = 64'h27;
    for (int i = 0; i < 3; i++) begin
      exp_we = 1'b1; exp_addr = 4'(i); exp_reg = 5'd9; exp_data = vals[i];
      tick();
    end
    exp_we = 1'b0;
  endtask

  task automatic std_pass_prog();
    prog.delete();
    prog.push_back(wr(5'd9, 64'd1));
    prog.push_back(wr(5'd9, 64'd2));
    prog.push_back(wr(5'd9, 64'h27));
    prog.push_back(halt_r());
  endtask

  task automatic run_prog(input logic [4:0] n, input exp_t e, input bit poke);
    exp_t w;
    int   k;
    logic [31:0] held;
    num_exp = n;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cycle_cnt_start", cycle_cnt, 0);
    exp_q.push_back(e);
    foreach (prog[i]) begin
      chk("busy_in_run", busy, 1);
      wb_valid = prog[i].v; wb_inst = prog[i].inst; wb_wen = prog[i].wen;
      wb_reg = prog[i].rg; wb_data = prog[i].d;
      if (poke) begin
        exp_we = 1'b1; exp_addr = 4'd1; exp_reg = 5'd9; exp_data = 64'h55;
      end
      tick();
    end
    wb_valid = 1'b0;
    exp_we   = 1'b0;
    if (prog.size() > 0) chk("done_next_cycle", done, 1);
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("done_within_bound", done, 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("pass", pass, w.pass);
      chk("fail_code", fail_code, w.code);
      chk("err_idx", err_idx, w.idx);
      chk("err_data", err_data, w.data);
      chk("match_cnt", match_cnt, w.mcnt);
      chk("cycle_cnt", cycle_cnt, w.ccnt);
      chk("busy_after_done", busy, 0);
      held = w.ccnt;
      tick(); tick(); tick();
      chk("cycle_cnt_held", cycle_cnt, held);
      chk("done_held", done, 1);
    end
  endtask

  initial begin
    rst = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_reg = '0; exp_data = '0;
    num_exp = '0; start = 1'b0; wb_valid = 1'b0; wb_inst = '0; wb_wen = 1'b0;
    wb_reg = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_err_data", err_data, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);

    load_std_table();

    // full match then halt
    std_pass_prog();
    run_prog(5'd3, mk_exp(1'b1, 2'd0, 5'd0, 64'd0, 32'd3, 32'd4), 1'b0);

    // data mismatch on second entry
    prog.delete();
    prog.push_back(wr(5'd9, 64'd1));
    prog.push_back(wr(5'd9, 64'd3));
    run_prog(5'd3, mk_exp(1'b0, 2'd1, 5'd1, 64'd3, 32'd1, 32'd2), 1'b0);

    // halt before all entries matched
    prog.delete();
    prog.push_back(wr(5'd9, 64'd1));
    prog.push_back(wr(5'd9, 64'd2));
    prog.push_back(halt_r());
    run_prog(5'd3, mk_exp(1'b0, 2'd2, 5'd2, 64'd0, 32'd2, 32'd3), 1'b0);

    // no retires: timeout with TIMEOUT=50
    prog.delete();
    run_prog(5'd3, mk_exp(1'b0, 2'd3, 5'd0, 64'd0, 32'd0, 32'd49), 1'b0);

    // ignored writes interleaved, table pokes during RUN
    prog.delete();
    prog.push_back(wr(5'd10, 64'h99));
    prog.push_back(wr(5'd9, 64'd1));
    prog.push_back(wr(5'd31, 64'h99));
    prog.push_back(bubble());
    prog.push_back(wr(5'd9, 64'd2));
    prog.push_back(wr(5'd10, 64'h99));
    prog.push_back(wr(5'd9, 64'h27));
    prog.push_back(wr(5'd9, 64'h99));
    prog.push_back(halt_r());
    run_prog(5'd3, mk_exp(1'b1, 2'd0, 5'd0, 64'd0, 32'd3, 32'd9), 1'b1);

    // re-run proves the RUN-time pokes did not land
    std_pass_prog();
    run_prog(5'd3, mk_exp(1'b1, 2'd0, 5'd0, 64'd0, 32'd3, 32'd4), 1'b0);

    // rst mid-run after one match
    num_exp = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wb_valid = 1'b1; wb_inst = ADDI; wb_wen = 1'b1; wb_reg = 5'd9; wb_data = 64'd1;
    tick();
    wb_valid = 1'b0;
    chk("mid_match_cnt", match_cnt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_match_cnt", match_cnt, 0);
    chk("mid_rst_cycle_cnt", cycle_cnt, 0);
    std_pass_prog();
    run_prog(5'd3, mk_exp(1'b1, 2'd0, 5'd0, 64'd0, 32'd3, 32'd4), 1'b0);

    // empty table: first halt passes, writes ignored
    prog.delete();
    prog.push_back(wr(5'd9, 64'd5));
    prog.push_back(halt_r());
    run_prog(5'd0, mk_exp(1'b1, 2'd0, 5'd0, 64'd0, 32'd0, 32'd2), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
